// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared issue-queue entry layout, memory-op meaning codes and branch type for the N-wide dispatch stage.
package dispatch_pkg;
    localparam int PC_LSB = 75;
    localparam int DST_LSB = 70;
    localparam int SRC0_LSB = 65;
    localparam int SRC1_LSB = 60;
    localparam int IMME_LSB = 28;
    localparam int TYPE_LSB = 24;
    localparam int MEANING_LSB = 18;
    localparam int DATA_VALID_LSB = 12;
    localparam int PTAB_LSB = 7;
    localparam int EXE_CODE_LSB = 2;
    localparam int DELOT_BIT = 1;
    localparam int BUSY_BIT = 0;
    localparam int TYPE_W = 4;
    localparam int MEANING_W = 6;
    localparam int DATA_VALID_W = 6;
    localparam int REG_W = 5;

    localparam logic [TYPE_W-1:0] TYPE_BRANCH = 4'h2;

    localparam logic [MEANING_W-1:0] MEANING_ADDU = 6'h01;
    localparam logic [MEANING_W-1:0] MEANING_LB = 6'h10;
    localparam logic [MEANING_W-1:0] MEANING_LBU = 6'h11;
    localparam logic [MEANING_W-1:0] MEANING_LH = 6'h12;
    localparam logic [MEANING_W-1:0] MEANING_LHU = 6'h13;
    localparam logic [MEANING_W-1:0] MEANING_LW = 6'h14;
    localparam logic [MEANING_W-1:0] MEANING_SB = 6'h18;
    localparam logic [MEANING_W-1:0] MEANING_SH = 6'h19;
    localparam logic [MEANING_W-1:0] MEANING_SW = 6'h1a;

    function automatic logic is_mem_op(input logic [MEANING_W-1:0] meaning);
        return meaning inside {MEANING_LB, MEANING_LBU, MEANING_LH, MEANING_LHU,
                               MEANING_LW, MEANING_SB, MEANING_SH, MEANING_SW};
    endfunction
endpackage

// File: rtl/dispatch_select.sv
// dispatch_select: longest in-order prefix of head entries within busy/memory-port limits.
// Branch/delay-slot pairing is enabled by DISPATCH_DELOT_PAIR_EN.
module dispatch_select
    import dispatch_pkg::*;
#(
    parameter int ISSUE_W = 2,
    parameter int MEM_PORTS = 1,
    parameter int ENTRY_W = 107,
    parameter int CNT_W = $clog2(ISSUE_W + 1)
) (
    input  logic [ISSUE_W*ENTRY_W-1:0] iq_entry,
    output logic [CNT_W-1:0]           len
);
    logic [ISSUE_W:0] elig;
    logic [ISSUE_W:0] delot;
    logic [ISSUE_W-1:0] go;
    logic ok;
    int mem;

    always_comb begin
        mem = 0;
        elig = '0;
        delot = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            mem += is_mem_op(iq_entry[i*ENTRY_W+MEANING_LSB +: MEANING_W]) ? 1 : 0;
            elig[i] = iq_entry[i*ENTRY_W+BUSY_BIT] && (mem <= MEM_PORTS);
            delot[i] = iq_entry[i*ENTRY_W+DELOT_BIT];
        end
    end

    // A branch needs its delay slot eligible in the next lane; the extra top bit of elig is 0.
    always_comb begin
        go = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
`ifdef DISPATCH_DELOT_PAIR_EN
            go[i] = elig[i] && ((iq_entry[i*ENTRY_W+TYPE_LSB +: TYPE_W] != TYPE_BRANCH) ||
                                (elig[i+1] && delot[i+1]));
`else
            go[i] = elig[i];
`endif
        end
    end

    always_comb begin
        len = '0;
        ok = 1'b1;
        for (int i = 0; i < ISSUE_W; i++) begin
            ok = ok && go[i];
            if (ok) len = CNT_W'(i + 1);
        end
    end
endmodule

// File: rtl/dispatch_nw.sv
// dispatch_nw: N-wide in-order dispatch with stall-holding per-lane EX registers.
// Optional DISPATCH_DELOT_PAIR_EN keeps a branch and its delay slot in the same group.
module dispatch_nw
    import dispatch_pkg::*;
#(
    parameter int ISSUE_W = 2,
    parameter int MEM_PORTS = 1,
    parameter int ENTRY_W = 107,
    parameter int CNT_W = $clog2(ISSUE_W + 1)
) (
    input  logic                       clk,
    input  logic                       rst_,
    input  logic                       flush,
    input  logic [ISSUE_W*ENTRY_W-1:0] iq_entry,
    output logic [CNT_W-1:0]           issue_count,
    input  logic                       ex_allin,
    output logic [ISSUE_W-1:0]         fu_valid,
    output logic [ISSUE_W*32-1:0]      fu_pc,
    output logic [ISSUE_W*5-1:0]       fu_dst,
    output logic [ISSUE_W*5-1:0]       fu_src0,
    output logic [ISSUE_W*5-1:0]       fu_src1,
    output logic [ISSUE_W*32-1:0]      fu_imme,
    output logic [ISSUE_W*6-1:0]       fu_meaning,
    output logic [ISSUE_W*6-1:0]       fu_data_valid,
    output logic [ISSUE_W*5-1:0]       fu_ptab_addr,
    output logic [ISSUE_W*5-1:0]       fu_exe_code,
    output logic [ISSUE_W-1:0]         fu_delot_flag
);
    logic [CNT_W-1:0] len;
    logic [ENTRY_W-1:0] held [ISSUE_W];
    logic out_free;

    dispatch_select #(
        .ISSUE_W(ISSUE_W), .MEM_PORTS(MEM_PORTS), .ENTRY_W(ENTRY_W), .CNT_W(CNT_W)
    ) u_select (
        .iq_entry(iq_entry),
        .len(len)
    );

    assign out_free = ~|fu_valid || ex_allin;
    assign issue_count = (out_free && !flush && rst_) ? len : '0;

    // Flush forces issue_count to 0, so it shares the load path and clears every lane.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            fu_valid <= '0;
            for (int i = 0; i < ISSUE_W; i++) held[i] <= '0;
        end else if (flush || out_free) begin
            for (int i = 0; i < ISSUE_W; i++) begin
                fu_valid[i] <= CNT_W'(i) < issue_count;
                held[i] <= (CNT_W'(i) < issue_count) ? iq_entry[i*ENTRY_W +: ENTRY_W] : '0;
            end
        end
    end

    for (genvar g = 0; g < ISSUE_W; g++) begin : g_lane
        assign fu_pc[g*32 +: 32] = held[g][PC_LSB +: 32];
        assign fu_dst[g*5 +: 5] = held[g][DST_LSB +: REG_W];
        assign fu_src0[g*5 +: 5] = held[g][SRC0_LSB +: REG_W];
        assign fu_src1[g*5 +: 5] = held[g][SRC1_LSB +: REG_W];
        assign fu_imme[g*32 +: 32] = held[g][IMME_LSB +: 32];
        assign fu_meaning[g*6 +: 6] = held[g][MEANING_LSB +: MEANING_W];
        assign fu_data_valid[g*6 +: 6] = held[g][DATA_VALID_LSB +: DATA_VALID_W];
        assign fu_ptab_addr[g*5 +: 5] = held[g][PTAB_LSB +: REG_W];
        assign fu_exe_code[g*5 +: 5] = held[g][EXE_CODE_LSB +: REG_W];
        assign fu_delot_flag[g] = held[g][DELOT_BIT];
    end
endmodule

// File: tb/tb_dispatch_nw.sv
// tb_dispatch_nw: directed self-checking bench for dispatch_nw at ISSUE_W=2, MEM_PORTS=1.
module tb_dispatch_nw;
    import dispatch_pkg::*;

    logic clk = 1'b0;
    logic rst_ = 1'b0;
    logic flush = 1'b0;
    logic [213:0] iq_entry = '0;
    logic [1:0] issue_count;
    logic ex_allin = 1'b1;
    logic [1:0] fu_valid;
    logic [63:0] fu_pc, fu_imme;
    logic [9:0] fu_dst, fu_src0, fu_src1, fu_ptab_addr, fu_exe_code;
    logic [11:0] fu_meaning, fu_data_valid;
    logic [1:0] fu_delot_flag;
    int checks = 0;
    int failures = 0;

    dispatch_nw dut (
        .clk(clk), .rst_(rst_), .flush(flush), .iq_entry(iq_entry),
        .issue_count(issue_count), .ex_allin(ex_allin), .fu_valid(fu_valid),
        .fu_pc(fu_pc), .fu_dst(fu_dst), .fu_src0(fu_src0), .fu_src1(fu_src1),
        .fu_imme(fu_imme), .fu_meaning(fu_meaning), .fu_data_valid(fu_data_valid),
        .fu_ptab_addr(fu_ptab_addr), .fu_exe_code(fu_exe_code), .fu_delot_flag(fu_delot_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [106:0] mk(input logic [31:0] pc, input logic [5:0] meaning,
                                        input logic busy, input logic [3:0] typ, input logic delot);
        return {pc, 5'd3, 5'd1, 5'd2, pc ^ 32'hA5A5_0000, typ, meaning, 6'h3f, 5'd7, 5'd0, delot, busy};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        iq_entry = {mk(32'h104, MEANING_ADDU, 1'b1, 4'h0, 1'b0), mk(32'h100, MEANING_ADDU, 1'b1, 4'h0, 1'b0)};
        #2;
        chk("reset_valid", 64'(fu_valid), 64'h0);
        chk("reset_count", 64'(issue_count), 64'h0);
        chk("reset_pc", fu_pc, 64'h0);
        @(negedge clk);
        rst_ = 1'b1;
        #1 chk("alu_pair_count", 64'(issue_count), 64'd2);
        @(negedge clk);
        chk("alu_pair_valid", 64'(fu_valid), 64'h3);
        chk("alu_pair_pc", fu_pc, 64'h0000_0104_0000_0100);
        chk("alu_pair_meaning", 64'(fu_meaning), 64'(12'h041));
        chk("alu_pair_imme", fu_imme, 64'hA5A5_0104_A5A5_0100);
        // LW then SW: only one memory port
        iq_entry = {mk(32'h204, MEANING_SW, 1'b1, 4'h0, 1'b0), mk(32'h200, MEANING_LW, 1'b1, 4'h0, 1'b0)};
        #1 chk("lw_sw_count", 64'(issue_count), 64'd1);
        @(negedge clk);
        chk("lw_valid", 64'(fu_valid), 64'h1);
        chk("lw_pc", fu_pc, 64'h0000_0000_0000_0200);
        iq_entry = {mk(32'h0, MEANING_ADDU, 1'b0, 4'h0, 1'b0), mk(32'h204, MEANING_SW, 1'b1, 4'h0, 1'b0)};
        #1 chk("sw_count", 64'(issue_count), 64'd1);
        @(negedge clk);
        chk("sw_valid", 64'(fu_valid), 64'h1);
        chk("sw_pc", fu_pc, 64'h0000_0000_0000_0204);
        // stall for three cycles
        iq_entry = {mk(32'h304, MEANING_LW, 1'b1, 4'h0, 1'b0), mk(32'h300, MEANING_ADDU, 1'b1, 4'h0, 1'b0)};
        ex_allin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_count", 64'(issue_count), 64'd0);
            @(negedge clk);
            chk("stall_valid", 64'(fu_valid), 64'h1);
            chk("stall_pc", fu_pc, 64'h0000_0000_0000_0204);
        end
        ex_allin = 1'b1;
        #1 chk("resume_count", 64'(issue_count), 64'd2);
        @(negedge clk);
        chk("resume_valid", 64'(fu_valid), 64'h3);
        chk("resume_pc", fu_pc, 64'h0000_0304_0000_0300);
        // flush beats stall, all busy
        ex_allin = 1'b0;
        flush = 1'b1;
        iq_entry = {mk(32'h404, MEANING_ADDU, 1'b1, 4'h0, 1'b0), mk(32'h400, MEANING_ADDU, 1'b1, 4'h0, 1'b0)};
        #1 chk("flush_count", 64'(issue_count), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_valid", 64'(fu_valid), 64'h0);
        chk("flush_pc", fu_pc, 64'h0);
        chk("flush_imme", fu_imme, 64'h0);
        chk("flush_dvalid", 64'(fu_data_valid), 64'h0);
        // empty queue head truncates everything
        iq_entry = {mk(32'h504, MEANING_ADDU, 1'b1, 4'h0, 1'b0), mk(32'h500, MEANING_ADDU, 1'b0, 4'h0, 1'b0)};
        #1 chk("empty_count", 64'(issue_count), 64'd0);
        iq_entry = {mk(32'h604, MEANING_LHU, 1'b1, 4'h0, 1'b0), mk(32'h600, MEANING_LB, 1'b1, 4'h0, 1'b0)};
        #1 chk("two_loads_count", 64'(issue_count), 64'd1);
        iq_entry = {mk(32'h704, MEANING_ADDU, 1'b0, 4'h0, 1'b1), mk(32'h700, MEANING_ADDU, 1'b1, TYPE_BRANCH, 1'b0)};
`ifdef DISPATCH_DELOT_PAIR_EN
        #1 chk("branch_alone_count", 64'(issue_count), 64'd0);
`else
        #1 chk("branch_alone_count", 64'(issue_count), 64'd1);
`endif
        iq_entry = {mk(32'h704, MEANING_ADDU, 1'b1, 4'h0, 1'b1), mk(32'h700, MEANING_ADDU, 1'b1, TYPE_BRANCH, 1'b0)};
        #1 chk("branch_pair_count", 64'(issue_count), 64'd2);
        @(negedge clk);
        chk("branch_pair_valid", 64'(fu_valid), 64'h3);
        chk("branch_pair_delot", 64'(fu_delot_flag), 64'h2);
        // asynchronous reset between clock edges
        #2 rst_ = 1'b0;
        #1;
        chk("async_valid", 64'(fu_valid), 64'h0);
        chk("async_pc", fu_pc, 64'h0);
        chk("async_count", 64'(issue_count), 64'd0);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dispatch_nw.md
Name: dispatch_nw

Overview:
- Parametrised N-wide in-order dispatch stage between issue_queue and the EX functional units; successor to the fixed 2-wide dispatch.
- Each cycle it selects the longest in-order prefix of issue-queue head entries that satisfies the structural limits (memory ports, EX backpressure).
- Selected entries are registered into per-lane EX pipeline registers. The consumed count is returned to issue_queue.
- Output registers hold their contents under EX stall (true valid/ready), instead of dropping instructions.

Parameters:
- ISSUE_W, 2, number of dispatch lanes (1..4).
- MEM_PORTS, 1, maximum load/store instructions dispatched per group (1..ISSUE_W).
- ENTRY_W, 107, issue-queue entry width. The field layout is fixed; see Behaviour.
- CNT_W, $clog2(ISSUE_W+1), width of issue_count.

Ports:
- clk  in  1  clock, rising edge.
- rst_  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush (exception/mispredict).
- iq_entry  in  ISSUE_W*ENTRY_W  head entries; lane i occupies bits [i*ENTRY_W +: ENTRY_W]; lane 0 is oldest.
- issue_count  out  CNT_W  number of head entries consumed this cycle. Combinational. issue_queue pops this many at the clock edge.
- ex_allin  in  1  EX accepts the current output group this cycle.
- fu_valid  out  ISSUE_W  per-lane valid (registered).
- fu_pc  out  ISSUE_W*32  per-lane PC.
- fu_dst, fu_src0, fu_src1  out  ISSUE_W*5 each  per-lane register indices.
- fu_imme  out  ISSUE_W*32  per-lane immediate.
- fu_meaning  out  ISSUE_W*6  per-lane instruction meaning.
- fu_data_valid  out  ISSUE_W*6  per-lane operand-valid bits.
- fu_ptab_addr, fu_exe_code  out  ISSUE_W*5 each  per-lane PTAB index and exception code.
- fu_delot_flag  out  ISSUE_W  per-lane delay-slot flag.

Behaviour:
- Entry field layout (MSB to LSB):
  - pc[106:75], dst[74:70], src0[69:65], src1[64:60], imme[59:28]
  - type[27:24], meaning[23:18], data_valid[17:12]
  - ptab_addr[11:7], exe_code[6:2], delot_flag[1], busy[0]
- Reset: every fu_* output is 0 and all fu_valid are 0. issue_count is 0 while rst_ is low. Assertion mid-group discards the held group.
- Output acceptance: out_free = (fu_valid == 0) | ex_allin.
- Lane eligibility: lane i is eligible when busy_i=1 and the number of memory ops among lanes 0..i is ≤ MEM_PORTS.
  - Memory op = meaning in {LB, LBU, LH, LHU, LW, SB, SH, SW}, evaluated per lane on that lane's own meaning.
- Prefix rule: lane i issues only if lanes 0..i-1 all issue. The first ineligible lane truncates the group.
- issue_count = out_free & !flush ? (length of prefix) : 0.
- Register update on the clock edge:
  - flush=1: all fu_valid cleared to 0, data fields zeroed.
  - Else if out_free: lanes < issue_count load their entry fields with fu_valid=1; lanes ≥ issue_count load zeros with fu_valid=0.
  - Else (stall): all output registers hold their values.
- Latency: 1 cycle from iq_entry to fu_* outputs. Throughput: one group per cycle when ex_allin=1.
- Simultaneous events:
  - flush with ex_allin=0: flush wins.
  - flush with all busy: issue_count=0, nothing is popped.
- Empty queue (lane 0 not busy): issue_count=0. If out_free, outputs become invalid/zero.

Optional Feature:
- DISPATCH_DELOT_PAIR_EN defined: a lane whose type == TYPE_BRANCH issues only if lane i+1 also issues in the same group, and that lane has busy=1 and delot_flag=1. Otherwise the group is truncated before the branch.
  - A branch in the last lane is therefore never issued there; it waits to become a lower lane.
  - The branch plus its delay slot count together against MEM_PORTS.
- Undefined: no branch/delay-slot coupling. A delay slot may issue in the group after its branch.

Decomposition:
- Shared package dispatch_pkg holds:
  - the entry field offsets and widths;
  - the memory-op meaning codes (from isa.h);
  - TYPE_BRANCH;
  - the function is_mem_op(meaning).
- One sub-module, dispatch_select: combinational prefix/eligibility logic producing the issue length. The parent holds the output registers and the handshake.

Test Plan (ISSUE_W=2, MEM_PORTS=1):
- Two ALU entries (busy=1, meaning ADDU), ex_allin=1 → issue_count=2. Next cycle fu_valid=2'b11 and fu_pc matches lane 0 then lane 1.
- Lane 0 = LW, lane 1 = SW → issue_count=1; fu_valid=2'b01. The next cycle issues the SW alone.
- Lane 0 = ADDU, lane 1 = LW, with ex_allin=0 and fu_valid≠0 → issue_count=0. Outputs stay stable for 3 stalled cycles, then advance on ex_allin=1.
- flush=1 while fu_valid=2'b11 and ex_allin=0 → issue_count=0. Next cycle fu_valid=0 and all fields are 0.
- Assert rst_ low asynchronously mid-cycle with valid outputs → fu_valid=0 immediately, without waiting for a clock edge.
- With DISPATCH_DELOT_PAIR_EN defined: lane 0 branch, lane 1 not busy → issue_count=0. With lane 1 busy and delot_flag=1 → issue_count=2.
